// File: rtl/qpp_deinterleaver.sv
// QPP block deinterleaver.
// Accepts one block of K samples in interleaved order and emits them in natural order.
// Input sample i is written to RAM address pi(i) = (f1*i + f2*i^2) mod K. The address is
// produced by the multiplier-free recursion:
//   pi(i+1) = pi(i) + g(i),  g(i+1) = g(i) + 2*f2  (all mod K).
// After the block is loaded, the RAM is read back in address order through a two-stage
// pipeline: the synchronous RAM read register, then the output register.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_valid       one-cycle strobe; latches f1, f2, K when idle and K != 0
//   f1, f2, K       QPP coefficients (each < K) and block length
//   s_data/s_valid/s_ready   interleaved-order input stream
//   m_data/m_valid/m_ready   natural-order output stream, m_last marks index K-1
//   busy            high whenever a block is in progress
module qpp_deinterleaver #(
  parameter int unsigned DATA_WIDTH   = 9,
  parameter int unsigned COUNT_WIDTH  = 13,
  parameter int unsigned SAMPLE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [DATA_WIDTH:0]     f1,
  input  logic [DATA_WIDTH:0]     f2,
  input  logic [COUNT_WIDTH-1:0]  K,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [SAMPLE_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy
);

  localparam int unsigned Depth = 2 ** COUNT_WIDTH;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StLoad,
    StDrain
  } state_e;

  state_e state_q, state_d;

  // Both operands are < k, so one conditional subtract fully reduces the sum.
  function automatic cnt_t mod_add(input cnt_t a, input cnt_t b, input cnt_t k);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) begin
      sum = sum - {1'b0, k};
    end
    return sum[COUNT_WIDTH-1:0];
  endfunction

  cnt_t k_q, f1_q, f2_q;
  cnt_t pi_q, g_q, d_q, i_q;
  cnt_t rd_addr_q;

  logic                    s1_vld_q;
  logic                    s1_last_q;
  logic [SAMPLE_WIDTH-1:0] ram_q;
  logic [SAMPLE_WIDTH-1:0] mem [Depth];

  logic cfg_accept;
  logic in_hs;
  logic load_done;
  logic out_ready;
  logic rd_issue;
  logic drain_done;

  assign cfg_accept = (state_q == StIdle) && cfg_valid && (K != '0);
  assign in_hs      = (state_q == StLoad) && s_valid;
  assign load_done  = in_hs && (i_q == k_q - cnt_t'(1));
  // Whole read pipeline advances only when the output register is empty or being consumed.
  assign out_ready  = !m_valid || m_ready;
  assign rd_issue   = (state_q == StDrain) && out_ready && (rd_addr_q != k_q);
  assign drain_done = m_valid && m_ready && m_last;

  assign s_ready = (state_q == StLoad);
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_accept) state_d = StInit;
      StInit:  state_d = StLoad;
      StLoad:  if (load_done) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Configuration, index recursion and read-pipeline control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
      pi_q      <= '0;
      g_q       <= '0;
      d_q       <= '0;
      i_q       <= '0;
      rd_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      if (cfg_accept) begin
        k_q  <= K;
        f1_q <= cnt_t'(f1);
        f2_q <= cnt_t'(f2);
      end

      if (state_q == StInit) begin
        pi_q      <= '0;
        g_q       <= mod_add(f1_q, f2_q, k_q);
        d_q       <= mod_add(f2_q, f2_q, k_q);
        i_q       <= '0;
        rd_addr_q <= '0;
      end

      if (in_hs) begin
        pi_q <= mod_add(pi_q, g_q, k_q);
        g_q  <= mod_add(g_q, d_q, k_q);
        i_q  <= i_q + cnt_t'(1);
      end

      if (out_ready) begin
        m_valid <= s1_vld_q;
        m_last  <= s1_last_q;
        if (s1_vld_q) begin
          m_data <= ram_q;
        end
        s1_vld_q  <= rd_issue;
        s1_last_q <= rd_issue && (rd_addr_q == k_q - cnt_t'(1));
        if (rd_issue) begin
          rd_addr_q <= rd_addr_q + cnt_t'(1);
        end
      end
    end
  end

  // Sample RAM: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[pi_q] <= s_data;
    end
    if (rd_issue) begin
      ram_q <= mem[rd_addr_q];
    end
  end

endmodule

// File: doc/qpp_deinterleaver.md
Name: qpp_deinterleaver

Overview:
- Receive-side inverse of the QPP index generator: accepts one block of K samples arriving in interleaved order and emits them in natural order.
- Input sample i belongs at natural position Π(i) = (f1·i + f2·i²) mod K.
- Π(i) is generated internally by the recursive form, with no multipliers.
- Sits after the channel or decoder stage. The output stream is streaming with backpressure.

Parameters:
DATA_WIDTH, 9, f1/f2 ports are DATA_WIDTH+1 bits
COUNT_WIDTH, 13, width of K and of RAM address; RAM depth 2**COUNT_WIDTH
SAMPLE_WIDTH, 8, width of one sample

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  one-cycle strobe, latches f1/f2/K
f1  in  DATA_WIDTH+1  QPP coefficient f1, must be < K
f2  in  DATA_WIDTH+1  QPP coefficient f2, must be < K
K  in  COUNT_WIDTH  block length, 40..2**COUNT_WIDTH-1
s_data  in  SAMPLE_WIDTH  input sample, interleaved order
s_valid  in  1  s_data valid
s_ready  out  1  block accepts s_data
m_data  out  SAMPLE_WIDTH  output sample, natural order
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data
m_last  out  1  marks natural index K-1
busy  out  1  high whenever not IDLE

Behaviour:
- Reset (async assert, sync release): IDLE; s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0; counters and Π/g registers cleared. RAM contents are don't-care.
- Reset mid-block aborts the block at once. No partial output follows release.

State machine IDLE -> INIT -> LOAD -> DRAIN -> IDLE:
- IDLE:
  - cfg_valid with K!=0 latches f1, f2, K; goes to INIT.
  - cfg_valid with K==0 is ignored.
  - cfg_valid in any other state is ignored.
- INIT (1 cycle):
  - Π=0, g=(f1+f2) mod K.
  - d=(2·f2) mod K.
  - i=0.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: RAM[Π]<=s_data; Π<=(Π+g) mod K; g<=(g+d) mod K; i<=i+1.
  - When the K-th sample is accepted (i==K-1): s_ready drops next cycle and the state goes to DRAIN.
- DRAIN:
  - Reads RAM addresses 0..K-1 in order.
  - Synchronous RAM read plus one output register.
  - First m_valid asserts exactly 2 cycles after the last LOAD handshake.
  - m_data/m_valid/m_last are held stable while m_valid&&!m_ready.
  - With m_ready held high, one sample per cycle.
  - Read address advances only when the output register is empty or being consumed; no sample is dropped or duplicated.
  - m_last=1 with sample K-1 only.
  - After that handshake: m_valid=0, back to IDLE, busy=0 the next cycle.

Arithmetic:
- Every mod-K addition is a single compare-subtract: sum=a+b on COUNT_WIDTH+1 bits, result=sum>=K ? sum-K : sum. This is valid because both operands are < K.
- d: 2·f2 (≤2K-2) reduced with one subtract.

Other rules:
- s_data presented while s_ready=0 is not consumed.
- No input and output overlap within a block. A new block needs a new cfg_valid after busy falls.
- The Π sequence exactly matches the index generator's output for the same f1/f2/K.

Test Plan:
- K=40, f1=3, f2=10, input s_data=i for i=0..39:
  - out[0]=0, out[13]=1, out[6]=2, out[19]=3.
  - All 40 positions compared against a Python/MATLAB reference; m_last on 40th output only.
- K=160, f1=21, f2=120, input=i: out[141]=1, out[42]=2; full 160-sample compare.
- Round trip at K=5952, f1=47, f2=186:
  - Drive x[Π(i)] using Π from the index generator for random x; output equals x.
  - Total cycles from cfg_valid with s_valid and m_ready high: 1+1+5952+2+5951.
- Backpressure at K=1984, f1=185, f2=124:
  - Random s_valid and m_ready at 50%; output sequence identical to the no-stall run.
  - m_data stable during every stall.
- Robustness at K=4736, f1=71, f2=444:
  - cfg_valid pulsed in LOAD and in DRAIN is ignored; block completes with the original parameters.
  - rst_n asserted after 1000 inputs: all outputs 0 immediately and busy=0.
  - The following K=40 block is correct.
- cfg_valid with K=0 -> stays IDLE, busy=0, s_ready=0.
